fetch_decode_unit: RTL and testbench
====================================

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RST_F  input  1  asynchronous, active-low reset; low clears all state immediately, independent of CLK.
REQ-003 SHALL have port PC_RST  input  1  synchronous active-high PC clear from ctrl.
REQ-004 SHALL have port PC_WRITE  input  1  PC update strobe from ctrl; also starts an instruction fetch.
REQ-005 SHALL have port PC_SEL  input  1  0 = next PC is PC+1, 1 = next PC is branch target.
REQ-006 SHALL have port BR_SEL  input  1  1 = absolute branch (target = IMM), 0 = relative branch (target = PC + sign-extended IMM).
REQ-007 SHALL have port IMEM_ADDR  output  16  instruction memory word address.
REQ-008 SHALL have port IMEM_REQ  output  1  read request to instruction memory.
REQ-009 SHALL have port IMEM_ACK  input  1  read data valid from instruction memory.
REQ-010 SHALL have port IMEM_DATA  input  32  instruction word; sampled only when IMEM_REQ and IMEM_ACK both high.
REQ-011 SHALL have port ALU_FLAGS  input  4  condition flags from ALU.
REQ-012 SHALL have port STAT_WE  input  1  status register write enable.
REQ-013 SHALL have ports OPCODE, MM  output  4 each  instruction fields IR[31:28], IR[27:24].
REQ-014 SHALL have port IMM  output  16  instruction field IR[15:0].
REQ-015 SHALL have port STAT  output  4  registered status flags.
REQ-016 SHALL have ports PC  output  16 and IR_VALID  output  1 (IR holds a complete fetched word), and BUSY  output  1 (fetch outstanding).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-018 SHALL in IDLE, on PC_WRITE=1, capture current PC into IMEM_ADDR, assert IMEM_REQ, clear IR_VALID, go to REQ next cycle.
REQ-019 SHALL in REQ hold IMEM_REQ=1 and IMEM_ADDR stable until IMEM_ACK=1; zero-cycle ACK (same edge) latches IR and goes to DONE.
REQ-020 SHALL in DONE drive IMEM_REQ=0, IR_VALID=1, and return to IDLE next cycle; IR_VALID remains 1 until the next fetch starts.
REQ-021 SHALL assert BUSY in REQ only; PC_WRITE while BUSY is ignored for fetch but still updates PC per REQ-022.
REQ-022 SHALL on PC_WRITE=1 update PC on the same edge: PC_SEL=0 -> PC+1; PC_SEL=1,BR_SEL=1 -> IMM; PC_SEL=1,BR_SEL=0 -> PC+sign-extended IMM; modulo 2^16 wrap, no overflow flag.
REQ-023 SHALL use the pre-update PC as the fetch address (fetch of instruction at PC, then PC advances).
REQ-024 SHALL give PC_RST priority over PC_WRITE: PC_RST=1 -> PC=0 next edge, FSM to IDLE, IMEM_REQ=0.
REQ-025 SHALL load STAT <= ALU_FLAGS on edge with STAT_WE=1; otherwise hold.
REQ-026 SHALL drive OPCODE, MM, IMM directly from IR (registered, glitch-free); IR changes only on accepted IMEM_ACK.
REQ-027 SHALL ignore IMEM_ACK in IDLE and DONE (stray ACK does not alter IR).

Reset
REQ-028 SHALL on RST_F=0 asynchronously set PC=0, IR=0 (OPCODE=0 noop), STAT=0, IR_VALID=0, IMEM_REQ=0, IMEM_ADDR=0, BUSY=0, FSM=IDLE.
REQ-029 SHALL abandon any outstanding fetch on reset mid-REQ; first post-reset fetch starts only on a new PC_WRITE.

Verification
REQ-030 Reset then PC_WRITE=1,PC_SEL=0 with IMEM_ACK after 2 cycles, IMEM_DATA=0x8_0_00_0005 -> IMEM_ADDR=0, PC=1, OPCODE=8, MM=0, IMM=0x0005, IR_VALID=1.
REQ-031 PC=0x0010, PC_WRITE=1,PC_SEL=1,BR_SEL=0,IMM=0xFFFE -> PC=0x000E; BR_SEL=1,IMM=0x0040 -> PC=0x0040.
REQ-032 PC=0xFFFF, PC_WRITE=1,PC_SEL=0 -> PC=0x0000.
REQ-033 STAT_WE=1,ALU_FLAGS=4'b1010 -> STAT=1010 next edge; STAT_WE=0,ALU_FLAGS=0101 -> STAT stays 1010.
REQ-034 RST_F low mid-REQ between edges -> IMEM_REQ=0, PC=0 immediately; later IMEM_ACK with data 0xF0000000 -> OPCODE stays 0.
REQ-035 PC_RST=1 and PC_WRITE=1 same cycle -> PC=0, no IMEM_REQ; stray IMEM_ACK in IDLE -> IR unchanged.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: holds the program counter, issues single-word
// instruction fetches, latches the returned word into IR, decodes its fields,
// and keeps a small status-flag register loaded from the ALU.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no fetch outstanding; PC_WRITE starts a fetch at the current PC
// REQ   | fetch outstanding; IMEM_REQ/IMEM_ADDR held until IMEM_ACK
// DONE  | word latched into IR; one-cycle completion slot, then IDLE
module fetch_decode_unit (
  input  logic        CLK,
  input  logic        RST_F,
  input  logic        PC_RST,
  input  logic        PC_WRITE,
  input  logic        PC_SEL,
  input  logic        BR_SEL,
  output logic [15:0] IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  input  logic [3:0]  ALU_FLAGS,
  input  logic        STAT_WE,
  output logic [3:0]  OPCODE,
  output logic [3:0]  MM,
  output logic [15:0] IMM,
  output logic [3:0]  STAT,
  output logic [15:0] PC,
  output logic        IR_VALID,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [31:0] ir_q;
  logic [15:0] addr_q;
  logic        req_q;
  logic        busy_q;
  logic        ir_valid_q;
  logic [3:0]  stat_q;

  // Next PC; the branch offset is the IMM field of the instruction already in IR.
  // IMM is as wide as PC, so sign extension is the identity and a 16-bit add
  // gives the wrap-around relative branch directly.
  always_comb begin
    pc_d = pc_q;
    if (PC_RST) begin
      pc_d = '0;
    end else if (PC_WRITE) begin
      if (!PC_SEL) begin
        pc_d = pc_q + 16'd1;
      end else if (BR_SEL) begin
        pc_d = ir_q[15:0];
      end else begin
        pc_d = pc_q + ir_q[15:0];
      end
    end
  end

  // PC register; updates on every PC_WRITE regardless of fetch state.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fetch sequencer with registered request/address/valid outputs.
  // A fetch samples the pre-update PC, so the instruction at PC is fetched
  // while PC itself moves on. PC_RST abandons an outstanding fetch without
  // touching IR.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
    end else if (PC_RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (PC_WRITE) begin
            addr_q     <= pc_q;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            ir_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_q && IMEM_ACK) begin
            ir_q       <= IMEM_DATA;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Status flags, loaded from the ALU on request and otherwise held.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      stat_q <= '0;
    end else if (STAT_WE) begin
      stat_q <= ALU_FLAGS;
    end
  end

  assign IMEM_ADDR = addr_q;
  assign IMEM_REQ  = req_q;
  assign BUSY      = busy_q;
  assign IR_VALID  = ir_valid_q;
  assign PC        = pc_q;
  assign STAT      = stat_q;
  assign OPCODE    = ir_q[31:28];
  assign MM        = ir_q[27:24];
  assign IMM       = ir_q[15:0];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: a behavioural model of the fetch/PC/status
// rules is stepped on every rising edge and compared against the DUT on every
// falling edge; directed sequences add hand-computed literal checks.
module tb_fetch_decode_unit;

  logic        CLK = 1'b0;
  logic        RST_F = 1'b0;
  logic        PC_RST = 1'b0;
  logic        PC_WRITE = 1'b0;
  logic        PC_SEL = 1'b0;
  logic        BR_SEL = 1'b0;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_DATA = '0;
  logic [3:0]  ALU_FLAGS = '0;
  logic        STAT_WE = 1'b0;
  logic [3:0]  OPCODE;
  logic [3:0]  MM;
  logic [15:0] IMM;
  logic [3:0]  STAT;
  logic [15:0] PC;
  logic        IR_VALID;
  logic        BUSY;

  fetch_decode_unit dut (
    .CLK(CLK), .RST_F(RST_F), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE),
    .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .ALU_FLAGS(ALU_FLAGS), .STAT_WE(STAT_WE), .OPCODE(OPCODE), .MM(MM),
    .IMM(IMM), .STAT(STAT), .PC(PC), .IR_VALID(IR_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model state: architectural values plus whether a fetch is outstanding and
  // whether the cycle right after a completed fetch is in progress.
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_ir;
  logic [3:0]  m_stat;
  logic        m_valid, m_pending, m_just_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_ir = '0; m_stat = '0;
    m_valid = 1'b0; m_pending = 1'b0; m_just_done = 1'b0;
  endtask

  // Model step on each rising edge while out of reset.
  always @(posedge CLK) begin
    if (RST_F) begin
      logic        can_start;
      logic [15:0] next_pc;
      can_start = PC_WRITE && !m_pending && !m_just_done;
      next_pc = m_pc;
      if (PC_WRITE) begin
        if (!PC_SEL)     next_pc = m_pc + 16'd1;
        else if (BR_SEL) next_pc = m_ir[15:0];
        else             next_pc = 16'((32'(m_pc) + 32'(m_ir[15:0])) % 32'h10000);
      end
      if (STAT_WE) m_stat = ALU_FLAGS;
      if (PC_RST) begin
        m_pc = '0;
        m_pending = 1'b0;
        m_just_done = 1'b0;
      end else begin
        if (m_pending && IMEM_ACK) begin
          m_ir = IMEM_DATA;
          m_valid = 1'b1;
          m_pending = 1'b0;
          m_just_done = 1'b1;
        end else begin
          m_just_done = 1'b0;
          if (can_start) begin
            m_addr = m_pc;
            m_pending = 1'b1;
            m_valid = 1'b0;
          end
        end
        m_pc = next_pc;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("pc", 32'(PC), 32'(m_pc));
      chk("imem_req", 32'(IMEM_REQ), 32'(m_pending));
      chk("busy", 32'(BUSY), 32'(m_pending));
      chk("imem_addr", 32'(IMEM_ADDR), 32'(m_addr));
      chk("opcode", 32'(OPCODE), 32'(m_ir[31:28]));
      chk("mm", 32'(MM), 32'(m_ir[27:24]));
      chk("imm", 32'(IMM), 32'(m_ir[15:0]));
      chk("stat", 32'(STAT), 32'(m_stat));
      chk("ir_valid", 32'(IR_VALID), 32'(m_valid));
    end
  end

  task automatic cyc(input logic pw, input logic psel, input logic bsel,
                     input logic ack, input logic [31:0] data);
    PC_WRITE = pw; PC_SEL = psel; BR_SEL = bsel;
    IMEM_ACK = ack; IMEM_DATA = data;
    @(posedge CLK);
    #1;
    PC_RST = 1'b0;
    STAT_WE = 1'b0;
    PC_WRITE = 1'b0;
    IMEM_ACK = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_req", 32'(IMEM_REQ), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_opcode", 32'(OPCODE), 32'h0);
    chk("rst_valid", 32'(IR_VALID), 32'h0);
    RST_F = 1'b1;
    cmp_en = 1'b1;

    // Fetch at PC 0, ACK on the second REQ cycle.
    cyc(1, 0, 0, 0, 32'h0);
    chk("f0_req", 32'(IMEM_REQ), 32'h1);
    chk("f0_busy", 32'(BUSY), 32'h1);
    chk("f0_valid_clr", 32'(IR_VALID), 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h8000_0005);
    chk("f0_addr", 32'(IMEM_ADDR), 32'h0);
    chk("f0_pc", 32'(PC), 32'h1);
    chk("f0_opcode", 32'(OPCODE), 32'h8);
    chk("f0_mm", 32'(MM), 32'h0);
    chk("f0_imm", 32'(IMM), 32'h0005);
    chk("f0_valid", 32'(IR_VALID), 32'h1);
    chk("f0_req_done", 32'(IMEM_REQ), 32'h0);
    cyc(0, 0, 0, 0, 32'h0);

    // Fetch with a same-cycle ACK; IMM becomes 0x0010.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h2000_0010);
    cyc(0, 0, 0, 0, 32'h0);
    // Absolute branch to 0x0010, starts fetch at PC 2.
    cyc(1, 1, 1, 0, 32'h0);
    chk("abs_pc", 32'(PC), 32'h0010);
    chk("abs_addr", 32'(IMEM_ADDR), 32'h2);
    // PC_WRITE while busy: PC moves, fetch address stays.
    cyc(1, 0, 0, 0, 32'h0);
    chk("busy_pc", 32'(PC), 32'h0011);
    chk("busy_addr", 32'(IMEM_ADDR), 32'h2);
    // Absolute branch back to 0x0010 on the ACK edge; IMM becomes 0xFFFE.
    cyc(1, 1, 1, 1, 32'h3000_FFFE);
    chk("abs2_pc", 32'(PC), 32'h0010);
    // Relative branch by -2 during the completion cycle: no new fetch.
    cyc(1, 1, 0, 0, 32'h0);
    chk("rel_pc", 32'(PC), 32'h000E);
    chk("rel_nofetch", 32'(IMEM_REQ), 32'h0);
    // Load IMM 0x0040, then absolute branch to it.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h4000_0040);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    chk("abs3_pc", 32'(PC), 32'h0040);
    chk("abs3_addr", 32'(IMEM_ADDR), 32'h000F);
    // PC_RST mid-fetch abandons it.
    PC_RST = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    chk("pcrst_pc", 32'(PC), 32'h0);
    chk("pcrst_req", 32'(IMEM_REQ), 32'h0);
    cyc(0, 0, 0, 1, 32'h7000_0000);
    chk("stray_idle_op", 32'(OPCODE), 32'h4);

    // Wrap from 0xFFFF to 0x0000.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h5000_FFFF);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    chk("ffff_pc", 32'(PC), 32'hFFFF);
    cyc(1, 0, 0, 1, 32'h6000_0001);
    chk("wrap_pc", 32'(PC), 32'h0000);
    cyc(0, 0, 0, 1, 32'h7000_0000);
    chk("stray_done_op", 32'(OPCODE), 32'h6);
    cyc(0, 0, 0, 0, 32'h0);

    // Status register load and hold.
    STAT_WE = 1'b1; ALU_FLAGS = 4'b1010;
    cyc(0, 0, 0, 0, 32'h0);
    chk("stat_load", 32'(STAT), 32'hA);
    ALU_FLAGS = 4'b0101;
    cyc(0, 0, 0, 0, 32'h0);
    chk("stat_hold", 32'(STAT), 32'hA);
    STAT_WE = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    chk("stat_load2", 32'(STAT), 32'h5);

    // Asynchronous reset mid-fetch.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    #2;
    RST_F = 1'b0;
    #1;
    model_reset();
    chk("arst_req", 32'(IMEM_REQ), 32'h0);
    chk("arst_pc", 32'(PC), 32'h0);
    chk("arst_busy", 32'(BUSY), 32'h0);
    chk("arst_stat", 32'(STAT), 32'h0);
    #3;
    RST_F = 1'b1;
    cyc(0, 0, 0, 1, 32'hF000_0000);
    chk("arst_ack_op", 32'(OPCODE), 32'h0);
    chk("arst_ack_req", 32'(IMEM_REQ), 32'h0);

    // PC_RST wins over PC_WRITE; stray ACK in IDLE leaves IR alone.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h9000_0003);
    cyc(0, 0, 0, 0, 32'h0);
    PC_RST = 1'b1;
    cyc(1, 0, 0, 0, 32'h0);
    chk("prio_pc", 32'(PC), 32'h0);
    chk("prio_req", 32'(IMEM_REQ), 32'h0);
    cyc(0, 0, 0, 1, 32'hA000_0000);
    chk("prio_stray_op", 32'(OPCODE), 32'h9);
    cyc(0, 0, 0, 0, 32'h0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
